// File: rtl/dsp_pkg.sv
// dsp_pkg: shared widths, OPMODE bit positions and X/Z mux encodings for dsp48a1
package dsp_pkg;
  localparam int W_IN  = 18;
  localparam int W_MUL = 36;
  localparam int W_ACC = 48;
  localparam int OP_PRE_EN   = 4;
  localparam int OP_CIN      = 5;
  localparam int OP_PRE_SUB  = 6;
  localparam int OP_POST_SUB = 7;
  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;
  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;
endpackage

// File: rtl/dsp_pipe_stage.sv
// dsp_pipe_stage: optional async-reset pipeline register with enable, or a plain wire when EN=0
module dsp_pipe_stage #(
  parameter int WIDTH = 1,
  parameter int EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  generate
    if (EN != 0) begin : g_reg
      logic [WIDTH-1:0] r_q;
      // reset overrides enable; enable low holds the stored value
      always_ff @(posedge clk or posedge rst)
        if (rst) r_q <= '0;
        else if (ce) r_q <= d;
      assign q = r_q;
    end else begin : g_wire
      logic unused;
      assign unused = ^{clk, rst, ce};
      assign q = d;
    end
  endgenerate
endmodule

// File: rtl/dsp48a1.sv
// dsp48a1: pre-adder, 18x18 unsigned multiplier and 48-bit post-adder slice; DSP_PARAM_CHECK_EN enables parameter checks
module dsp48a1
  import dsp_pkg::*;
#(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic              clk,
  input  logic              RSTA,
  input  logic              RSTB,
  input  logic              RSTC,
  input  logic              RSTD,
  input  logic              RSTM,
  input  logic              RSTP,
  input  logic              RSTCARRYIN,
  input  logic              RSTOPMODE,
  input  logic              CEA,
  input  logic              CEB,
  input  logic              CEC,
  input  logic              CED,
  input  logic              CEM,
  input  logic              CEP,
  input  logic              CECARRYIN,
  input  logic              CEOPMODE,
  input  logic [W_IN-1:0]   A,
  input  logic [W_IN-1:0]   B,
  input  logic [W_IN-1:0]   BCIN,
  input  logic [W_IN-1:0]   D,
  input  logic [W_ACC-1:0]  C,
  input  logic [W_ACC-1:0]  PCIN,
  input  logic              CARRYIN,
  input  logic [7:0]        OPMODE,
  output logic [W_IN-1:0]   BCOUT,
  output logic [W_MUL-1:0]  M,
  output logic [W_ACC-1:0]  P,
  output logic [W_ACC-1:0]  PCOUT,
  output logic              CARRYOUT,
  output logic              CARRYOUTF
);
  localparam logic [1:0] CY_SRC = (CARRYINSEL == "OPMODE5") ? 2'd1 : (CARRYINSEL == "CARRYIN") ? 2'd2 : 2'd0;
  localparam logic [1:0] B_SRC  = (B_INPUT == "DIRECT") ? 2'd1 : (B_INPUT == "CASCADE") ? 2'd2 : 2'd0;

`ifdef DSP_PARAM_CHECK_EN
  // flag illegal parameterisations once at elaboration/time zero
  initial begin
    if (!(A0REG inside {0, 1}) || !(A1REG inside {0, 1}) || !(B0REG inside {0, 1}) ||
        !(B1REG inside {0, 1}) || !(CREG inside {0, 1}) || !(DREG inside {0, 1}) ||
        !(MREG inside {0, 1}) || !(PREG inside {0, 1}) || !(CARRYINREG inside {0, 1}) ||
        !(CARRYOUTREG inside {0, 1}) || !(OPMODEREG inside {0, 1}))
      $error("dsp48a1: register parameter outside 0/1");
    if (CY_SRC == 2'd0) $error("dsp48a1: illegal CARRYINSEL %s", CARRYINSEL);
    if (B_SRC == 2'd0) $error("dsp48a1: illegal B_INPUT %s", B_INPUT);
  end
`endif

  logic [7:0]       w_op;
  logic [W_IN-1:0]  w_a0, w_a1, w_bsrc, w_b0, w_b1, w_d, w_pre;
  logic [W_ACC-1:0] w_c, w_x, w_z;
  logic [W_MUL-1:0] w_mul, w_m;
  logic             w_cyi_d, w_cyi, w_co;
  logic [W_ACC:0]   w_sum;
  logic [W_ACC-1:0] w_p;

  assign w_bsrc = (B_SRC == 2'd1) ? B : (B_SRC == 2'd2) ? BCIN : '0;

  dsp_pipe_stage #(.WIDTH(8),     .EN(OPMODEREG)) u_op (.clk(clk), .rst(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(w_op));
  dsp_pipe_stage #(.WIDTH(W_IN),  .EN(A0REG))     u_a0 (.clk(clk), .rst(RSTA), .ce(CEA), .d(A),      .q(w_a0));
  dsp_pipe_stage #(.WIDTH(W_IN),  .EN(A1REG))     u_a1 (.clk(clk), .rst(RSTA), .ce(CEA), .d(w_a0),   .q(w_a1));
  dsp_pipe_stage #(.WIDTH(W_IN),  .EN(B0REG))     u_b0 (.clk(clk), .rst(RSTB), .ce(CEB), .d(w_bsrc), .q(w_b0));
  dsp_pipe_stage #(.WIDTH(W_IN),  .EN(B1REG))     u_b1 (.clk(clk), .rst(RSTB), .ce(CEB), .d(w_pre),  .q(w_b1));
  dsp_pipe_stage #(.WIDTH(W_IN),  .EN(DREG))      u_d  (.clk(clk), .rst(RSTD), .ce(CED), .d(D),      .q(w_d));
  dsp_pipe_stage #(.WIDTH(W_ACC), .EN(CREG))      u_c  (.clk(clk), .rst(RSTC), .ce(CEC), .d(C),      .q(w_c));
  dsp_pipe_stage #(.WIDTH(W_MUL), .EN(MREG))      u_m  (.clk(clk), .rst(RSTM), .ce(CEM), .d(w_mul),  .q(w_m));
  dsp_pipe_stage #(.WIDTH(1),     .EN(CARRYINREG))  u_cyi (.clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(w_cyi_d),      .q(w_cyi));
  dsp_pipe_stage #(.WIDTH(1),     .EN(CARRYOUTREG)) u_cyo (.clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(w_sum[W_ACC]), .q(w_co));
  dsp_pipe_stage #(.WIDTH(W_ACC), .EN(PREG))      u_p  (.clk(clk), .rst(RSTP), .ce(CEP), .d(w_sum[W_ACC-1:0]), .q(w_p));

  // pre-adder, multiplier, carry source and X/Z operand selection, all steered by the registered OPMODE
  always_comb begin
    w_pre   = w_op[OP_PRE_EN] ? (w_op[OP_PRE_SUB] ? w_d - w_b0 : w_d + w_b0) : w_b0;
    w_mul   = W_MUL'(w_a1) * W_MUL'(w_b1);
    w_cyi_d = (CY_SRC == 2'd1) ? w_op[OP_CIN] : (CY_SRC == 2'd2) ? CARRYIN : 1'b0;
    w_x     = (w_op[1:0] == X_M) ? W_ACC'(w_m) : (w_op[1:0] == X_P) ? w_p :
              (w_op[1:0] == X_DAB) ? {w_d[11:0], w_a1, w_b1} : '0;
    w_z     = (w_op[3:2] == Z_PCIN) ? PCIN : (w_op[3:2] == Z_P) ? w_p :
              (w_op[3:2] == Z_C) ? w_c : '0;
  end

  // 49-bit post-adder; bit 48 is the carry on add and the borrow on subtract
  always_comb begin
    w_sum = w_op[OP_POST_SUB] ? {1'b0, w_z} - ({1'b0, w_x} + (W_ACC+1)'(w_cyi))
                              : {1'b0, w_z} + {1'b0, w_x} + (W_ACC+1)'(w_cyi);
  end

  assign BCOUT     = w_b1;
  assign M         = w_m;
  assign P         = w_p;
  assign PCOUT     = w_p;
  assign CARRYOUT  = w_co;
  assign CARRYOUTF = w_co;
endmodule

// File: tb/tb_dsp48a1.sv
// tb_dsp48a1: directed vectors with queued expectations checked by a separate monitor process
module tb_dsp48a1;
  logic        clk = 1'b0;
  logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
  logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
  logic [17:0] A, B, BCIN, D;
  logic [47:0] C, PCIN;
  logic        CARRYIN;
  logic [7:0]  OPMODE;
  logic [17:0] BCOUT;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;

  dsp48a1 dut (
    .clk(clk), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM), .RSTP(RSTP),
    .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .A(A), .B(B), .BCIN(BCIN), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  always #5 clk = ~clk;

  typedef enum int {S_P, S_PCOUT, S_M, S_BCOUT, S_CO, S_COF} sel_t;
  typedef struct {
    sel_t        sel;
    logic [47:0] exp;
    string       nm;
  } chk_t;

  chk_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic smp = 1'b0;

  // monitor: whenever the outputs are presented, drain and compare all pending expectations
  always @(posedge smp) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [47:0] act;
      c = q.pop_front();
      case (c.sel)
        S_P:     act = P;
        S_PCOUT: act = PCOUT;
        S_M:     act = 48'(M);
        S_BCOUT: act = 48'(BCOUT);
        S_CO:    act = 48'(CARRYOUT);
        default: act = 48'(CARRYOUTF);
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", c.nm, act, c.exp);
      end
    end
  end

  task automatic expect_v(input sel_t s, input logic [47:0] e, input string n);
    chk_t c;
    c.sel = s; c.exp = e; c.nm = n;
    q.push_back(c);
  endtask

  task automatic present();
    smp = 1'b1;
    #1 smp = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_rst(input logic v);
    {RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE} = {8{v}};
  endtask

  task automatic expect_all(input logic [17:0] bc, input logic [35:0] m, input logic [47:0] p,
                            input logic co, input string n);
    expect_v(S_BCOUT, 48'(bc), {n, ".BCOUT"});
    expect_v(S_M,     48'(m),  {n, ".M"});
    expect_v(S_P,     p,       {n, ".P"});
    expect_v(S_PCOUT, p,       {n, ".PCOUT"});
    expect_v(S_CO,    48'(co), {n, ".CARRYOUT"});
    expect_v(S_COF,   48'(co), {n, ".CARRYOUTF"});
  endtask

  initial begin
    set_rst(1'b0);
    {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = 8'hFF;
    A = 18'($urandom); B = 18'($urandom); BCIN = 18'($urandom); D = 18'($urandom);
    C = {16'($urandom), 32'($urandom)}; PCIN = {16'($urandom), 32'($urandom)};
    CARRYIN = 1'b1; OPMODE = 8'($urandom);
    tick(3);
    // asynchronous reset with random enables: outputs clear without a clock edge
    {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = 8'($urandom);
    set_rst(1'b1);
    #1;
    expect_all(18'h0, 36'h0, 48'h0, 1'b0, "reset_async");
    present();
    tick(2);
    expect_all(18'h0, 36'h0, 48'h0, 1'b0, "reset_held");
    present();
    set_rst(1'b0);
    {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = 8'hFF;
    // pre-subtract D-B, multiply, C minus M
    A = 18'd20; B = 18'd10; D = 18'd25; C = 48'd350; PCIN = 48'd0; CARRYIN = 1'b0; BCIN = 18'd0;
    OPMODE = 8'hDD;
    tick(4);
    expect_all(18'h00F, 36'h12C, 48'h32, 1'b0, "op_dd");
    present();
    // pre-add D+B, X and Z zero
    OPMODE = 8'h10;
    tick(3);
    expect_v(S_BCOUT, 48'h23,  "op_10.BCOUT");
    expect_v(S_M,     48'h2BC, "op_10.M");
    expect_v(S_P,     48'h0,   "op_10.P");
    expect_v(S_CO,    48'h0,   "op_10.CARRYOUT");
    present();
    // pre-adder bypassed, P+P feedback of zero
    OPMODE = 8'h0A;
    tick(3);
    expect_v(S_BCOUT, 48'h0A, "op_0a.BCOUT");
    expect_v(S_M,     48'hC8, "op_0a.M");
    expect_v(S_P,     48'h0,  "op_0a.P");
    expect_v(S_CO,    48'h0,  "op_0a.CARRYOUT");
    present();
    // PCIN - ({D,A,B} + 1) wraps with borrow
    OPMODE = 8'hA7; A = 18'd5; B = 18'd6; D = 18'd25; PCIN = 48'd3000;
    tick(3);
    expect_all(18'd6, 36'h1E, 48'hFE6FFFEC0BB1, 1'b1, "op_a7");
    present();
    // P enable low: P frozen while inputs change
    CEP = 1'b0; OPMODE = 8'hDD; A = 18'd20; B = 18'd10; C = 48'd999;
    tick(3);
    expect_v(S_P,     48'hFE6FFFEC0BB1, "hold.P");
    expect_v(S_PCOUT, 48'hFE6FFFEC0BB1, "hold.PCOUT");
    expect_v(S_M,     48'd300,          "hold.M");
    present();
    // RSTP pulse between edges clears P immediately, other stages untouched
    RSTP = 1'b1;
    #1;
    expect_v(S_P,     48'h0,   "rstp.P");
    expect_v(S_PCOUT, 48'h0,   "rstp.PCOUT");
    expect_v(S_M,     48'd300, "rstp.M");
    expect_v(S_BCOUT, 48'h0F,  "rstp.BCOUT");
    present();
    RSTP = 1'b0;
    tick(1);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
